// File: rtl/perceptron_trainer.sv
// Trainable perceptron with registered weights and bias.
// A single multiplier accumulates one input per cycle, then the optional
// perceptron learning rule (rate 1) updates all weights in parallel with saturation.
//
// state | meaning
// IDLE  | waiting for a sample or a weight load
// MAC   | accumulating w[k]*x[k], one k per cycle
// ACT   | threshold the sum and register the result
// UPD   | apply the learning rule after a misprediction
// OUT   | result held until the consumer takes it
module perceptron_trainer #(
  parameter int N_IN = 2,
  parameter int IN_W = 4,
  parameter int W_W  = 8,
  localparam int ACC_W = W_W + IN_W + $clog2(N_IN + 1),
  localparam int A_W   = $clog2(N_IN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*IN_W-1:0]    in_x,
  input  logic                    in_train,
  input  logic                    in_label,
  input  logic                    ld_en,
  input  logic [A_W-1:0]          ld_addr,
  input  logic [W_W-1:0]          ld_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_y,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_upd,
  output logic [15:0]             err_cnt
);

  typedef enum logic [2:0] {IDLE, MAC, ACT, UPD, OUT} state_t;

  state_t state, state_nx;

  logic signed [W_W-1:0]      w [N_IN];
  logic signed [W_W-1:0]      b;
  logic signed [IN_W-1:0]     x [N_IN];
  logic                       train_r;
  logic                       label_r;
  logic [A_W-1:0]             k;
  logic signed [ACC_W-1:0]    acc;
  logic signed [W_W-1:0]      w_sel;
  logic signed [IN_W-1:0]     x_sel;
  logic signed [W_W+IN_W-1:0] prod;
  logic                       accept;
  logic                       y;
  logic                       err;
  logic                       last_k;

  // Clamp a one-bit-wider result back into the weight range.
  function automatic logic signed [W_W-1:0] sat(input logic signed [W_W:0] v);
    if (v[W_W] != v[W_W-1])
      sat = v[W_W] ? {1'b1, {(W_W-1){1'b0}}} : {1'b0, {(W_W-1){1'b1}}};
    else
      sat = v[W_W-1:0];
  endfunction

  // A load strobe in IDLE takes priority over accepting a sample.
  assign in_ready  = (state == IDLE) && !ld_en;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign y         = ~acc[ACC_W-1];
  assign err       = train_r && (y != label_r);
  assign last_k    = (k == A_W'(N_IN - 1));

  // Select the weight/input pair for the current MAC step.
  always_comb begin
    w_sel = '0;
    x_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (k == A_W'(i)) begin
        w_sel = w[i];
        x_sel = x[i];
      end
    end
  end

  assign prod = $signed({{IN_W{w_sel[W_W-1]}}, w_sel}) * $signed({{W_W{x_sel[IN_W-1]}}, x_sel});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MAC;
      MAC:     if (last_k) state_nx = ACT;
      ACT:     state_nx = err ? UPD : OUT;
      UPD:     state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: loads, sample capture, accumulation, result and weight updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        w[i] <= '0;
        x[i] <= '0;
      end
      b       <= '0;
      acc     <= '0;
      k       <= '0;
      train_r <= 1'b0;
      label_r <= 1'b0;
      out_y   <= 1'b0;
      out_sum <= '0;
      out_upd <= 1'b0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_en) begin
            for (int i = 0; i < N_IN; i++)
              if (ld_addr == A_W'(i)) w[i] <= ld_data;
            if (ld_addr == A_W'(N_IN)) b <= ld_data;
          end else if (accept) begin
            for (int i = 0; i < N_IN; i++)
              x[i] <= in_x[i*IN_W +: IN_W];
            train_r <= in_train;
            label_r <= in_label;
            acc     <= {{(ACC_W-W_W){b[W_W-1]}}, b};
            k       <= '0;
          end
        end
        MAC: begin
          acc <= acc + {{(ACC_W-W_W-IN_W){prod[W_W+IN_W-1]}}, prod};
          k   <= k + A_W'(1);
        end
        ACT: begin
          out_y   <= y;
          out_sum <= acc;
        end
        UPD: begin
          for (int i = 0; i < N_IN; i++) begin
            if (label_r)
              w[i] <= sat({w[i][W_W-1], w[i]} + {{(W_W+1-IN_W){x[i][IN_W-1]}}, x[i]});
            else
              w[i] <= sat({w[i][W_W-1], w[i]} - {{(W_W+1-IN_W){x[i][IN_W-1]}}, x[i]});
          end
          if (label_r) b <= sat({b[W_W-1], b} + {{W_W{1'b0}}, 1'b1});
          else         b <= sat({b[W_W-1], b} - {{W_W{1'b0}}, 1'b1});
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          out_upd <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_upd <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
